uart_console_in: RTL and testbench
==================================

Name: uart_console_in

Overview:
- Console-input source: deserialises 8N1 UART bytes from the board RX pin, buffers them, and presents each byte on the CONSOLE_IN / CONSOLE_IN_valid / CONSOLE_IN_ack interface consumed by Wrapper.
- Producer end of the console-input handshake; sits between the top-level RX pin and Wrapper's CONSOLE_IN ports.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200); minimum 4.
- FIFO_DEPTH, 4, receive buffer entries; power of 2, >= 2.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  reset; synchronous, active-high.
- RX  input  1  asynchronous UART line; idles high.
- CONSOLE_IN  output  8  byte presented to Wrapper.
- CONSOLE_IN_valid  output  1  CONSOLE_IN holds a valid byte.
- CONSOLE_IN_ack  input  1  Wrapper acknowledge.
- FRAMING_ERR  output  1  one-cycle pulse: bad stop bit (or bad parity, see optional feature).
- OVERRUN  output  1  one-cycle pulse: byte dropped because FIFO full.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; RX FSM IDLE; output FSM O_IDLE; FIFO empty; bit/baud counters 0; synchroniser flops reset to 1.
- RX path: 2-flop synchroniser; every RX reference below means the synchronised value.
- RX FSM:
  - IDLE: on RX=0 -> START; baud counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, resample RX. If 0 -> DATA. If 1 (glitch) -> IDLE, no error.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), LSB first; after 8 samples -> STOP.
  - STOP: sample once at mid-bit. If 1, push the byte (drop and pulse OVERRUN if the FIFO is full). If 0, discard and pulse FRAMING_ERR. Either way -> IDLE immediately, ready for a back-to-back start bit.
- Latency: byte visible in the FIFO on the cycle after the stop-bit sample. CONSOLE_IN_valid rises one further cycle later if the output FSM is in O_IDLE.
- Output FSM (4-phase handshake):
  - O_IDLE: valid=0. If FIFO non-empty, load head into the CONSOLE_IN register -> O_VALID.
  - O_VALID: valid=1; CONSOLE_IN stable. On ack=1 -> O_ACKED.
  - O_ACKED: valid=1 held until ack=0; then pop FIFO, valid=0 -> O_IDLE.
  - Result: at least one cycle of valid=0 between consecutive bytes.
- CONSOLE_IN holds its last value after valid drops; bench checks it only while valid=1.
- ack=1 while in O_IDLE is ignored.
- Simultaneous push and pop in one cycle: both take effect; occupancy unchanged. A full FIFO with a pop in the same cycle accepts the push (no overrun).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count register is log2(FIFO_DEPTH)+1 bits.
- RESET mid-frame or mid-handshake: frame abandoned, FIFO flushed, valid=0 on the next cycle regardless of ack.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: frame is 8E1. A parity bit is sampled after D7 (PARITY state); even-parity mismatch, or a bad stop bit, pulses FRAMING_ERR and discards the byte.
- Undefined: 8N1, no PARITY state.

Decomposition:
- Package uart_console_pkg holds:
  - RX state encoding: IDLE, START, DATA, (PARITY), STOP.
  - Output state encoding: O_IDLE, O_VALID, O_ACKED.
  - Constants: DATA_BITS=8; HALF_BIT=CLKS_PER_BIT/2 as a function.
- One sub-module, console_sync_fifo: parameterised width and depth; push/pop/full/empty; registered head output.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4; bench acks 3 cycles after valid, drops ack 2 cycles after ack rises):
- Serialise 0x50, 0x41, 0x0D back-to-back -> valid presents 0x50, 0x41, 0x0D in order; valid low >=1 cycle between bytes; FRAMING_ERR and OVERRUN never pulse.
- Serialise 0xA5, hold ack=0 for 100 cycles -> valid stays 1 and CONSOLE_IN=0xA5 stable throughout; single pop only after ack 1->0.
- 6 bytes 0x01..0x06 with ack held 0 -> first 4 buffered; OVERRUN pulses exactly twice (bytes 0x05, 0x06); acking afterwards yields 0x01..0x04.
- Frame 0x3C with stop bit 0 -> FRAMING_ERR one-cycle pulse, valid never rises; the following good frame 0x7E is delivered.
- 1-cycle low glitch on idle RX -> no byte, no error. RESET asserted mid-DATA of 0xFF with one byte pending -> valid=0 the next cycle; FIFO empty; the next frame 0x12 is delivered correctly.
- With UART_PARITY_EN: 0x03 with parity bit 0 -> delivered. 0x03 with parity bit 1 -> FRAMING_ERR pulse, byte discarded.

Source files
------------

// File: rtl/uart_console_pkg.sv
// ---------------------------------------------------------------------------
// uart_console_pkg
// Shared types and constants for the console-input UART receiver.
//   RxState   : receive FSM encoding (IDLE, START, DATA, [PARITY], STOP)
//   OutState  : output handshake FSM encoding (O_IDLE, O_VALID, O_ACKED)
//   DATA_BITS : payload bits per frame
//   half_bit(): number of clocks from start-edge detect to the start-bit
//               resample point
// Optional feature macro: UART_PARITY_EN (adds the PARITY state, 8E1 frames)
// ---------------------------------------------------------------------------
package uart_console_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } RxState;

    typedef enum logic [1:0] {
        O_IDLE  = 2'd0,
        O_VALID = 2'd1,
        O_ACKED = 2'd2
    } OutState;

    // Half a bit period, used to land the start-bit resample near mid-bit.
    function automatic int half_bit(input int clksPerBit);
        return clksPerBit / 2;
    endfunction

endpackage

// File: rtl/console_sync_fifo.sv
// ---------------------------------------------------------------------------
// console_sync_fifo
// Small synchronous FIFO buffering received bytes until the consumer takes
// them.
//   clk_i, reset_i : clock, synchronous active-high reset (flushes the FIFO)
//   push_i         : write pushData_i (ignored when full unless popping too)
//   pushData_i     : data to write
//   pop_i          : discard the head entry (ignored when empty)
//   headData_o     : oldest entry, read straight from the storage flops
//   full_o/empty_o : occupancy flags
// Pushing and popping in the same cycle both take effect, so a full FIFO
// that is being popped still accepts the incoming word.
// ---------------------------------------------------------------------------
module console_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_FULL);
    assign headData_o = mem_q[rdPtr_q];

    // A pop frees a slot in the same cycle, which is what lets a full FIFO
    // accept a simultaneous push.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Occupancy only moves when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_console_in.sv
// ---------------------------------------------------------------------------
// uart_console_in
// Console-input source: receives UART bytes from the RX pin, buffers them and
// offers each one to Wrapper over a 4-phase valid/ack handshake.
//   CLK              : system clock
//   RESET            : synchronous active-high reset
//   RX               : asynchronous UART line, idles high
//   CONSOLE_IN       : byte presented to Wrapper (held after valid drops)
//   CONSOLE_IN_valid : CONSOLE_IN holds a valid byte
//   CONSOLE_IN_ack   : Wrapper acknowledge
//   FRAMING_ERR      : one-cycle pulse, bad stop bit (or bad parity)
//   OVERRUN          : one-cycle pulse, byte dropped because the FIFO was full
// Parameters: CLKS_PER_BIT (>= 4), FIFO_DEPTH (power of 2, >= 2).
// Optional feature macro: UART_PARITY_EN selects 8E1 framing; without it the
// receiver expects 8N1.
// ---------------------------------------------------------------------------
module uart_console_in
    import uart_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] CONSOLE_IN,
    output logic       CONSOLE_IN_valid,
    input  logic       CONSOLE_IN_ack,
    output logic       FRAMING_ERR,
    output logic       OVERRUN
);

    localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int BITCNT_W = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0]   BAUD_ONE = BAUD_W'(1);
    localparam logic [BAUD_W-1:0]   BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]   HALF_END = BAUD_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [BITCNT_W-1:0] BIT_ONE  = BITCNT_W'(1);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(DATA_BITS - 1);

    logic                 rxMeta_q;
    logic                 rxSync_q;

    RxState               rxState_q;
    logic [BAUD_W-1:0]    baudCnt_q;
    logic [BITCNT_W-1:0]  bitCnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 framingErr_q;
    logic                 overrun_q;
`ifdef UART_PARITY_EN
    logic                 parityOk_q;
`endif

    OutState              outState_q;
    logic [7:0]           consoleData_q;
    logic                 consoleValid_q;

    logic                 frameOk;
    logic                 stopSample;
    logic                 rxPush;
    logic                 fifoPop;
    logic [7:0]           fifoHead;
    logic                 fifoFull;
    logic                 fifoEmpty;

    // Two-flop synchroniser; both flops reset to the idle line level so a
    // reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= RX;
            rxSync_q <= rxMeta_q;
        end
    end

`ifdef UART_PARITY_EN
    assign frameOk = rxSync_q && parityOk_q;
`else
    assign frameOk = rxSync_q;
`endif

    // The byte is written into the FIFO on the same edge that samples the
    // stop bit, so it is visible to the output side one cycle later.
    assign stopSample = (rxState_q == STOP) && (baudCnt_q == BIT_END);
    assign rxPush     = stopSample && frameOk;

    // Receive FSM: find the falling start edge, confirm it half a bit later,
    // then sample every full bit period from there (mid-bit), LSB first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxState_q    <= IDLE;
            baudCnt_q    <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            framingErr_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
            parityOk_q   <= 1'b0;
`endif
        end else begin
            framingErr_q <= 1'b0;
            overrun_q    <= rxPush && fifoFull && !fifoPop;
            case (rxState_q)
                IDLE: begin
                    baudCnt_q <= '0;
                    bitCnt_q  <= '0;
                    if (!rxSync_q) begin
                        rxState_q <= START;
                    end
                end
                START: begin
                    if (baudCnt_q == HALF_END) begin
                        baudCnt_q <= '0;
                        // A line that is high again was only a glitch.
                        rxState_q <= rxSync_q ? IDLE : DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baudCnt_q == BIT_END) begin
                        baudCnt_q <= '0;
                        shift_q   <= {rxSync_q, shift_q[DATA_BITS-1:1]};
                        bitCnt_q  <= bitCnt_q + BIT_ONE;
                        if (bitCnt_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rxState_q <= PARITY;
`else
                            rxState_q <= STOP;
`endif
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baudCnt_q == BIT_END) begin
                        baudCnt_q  <= '0;
                        // Even parity: the parity bit equals the XOR of the data.
                        parityOk_q <= (rxSync_q == ^shift_q);
                        rxState_q  <= STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end
`endif
                STOP: begin
                    if (baudCnt_q == BIT_END) begin
                        baudCnt_q <= '0;
                        if (!frameOk) begin
                            framingErr_q <= 1'b1;
                        end
                        // Leave mid stop bit so a back-to-back start edge is caught.
                        rxState_q <= IDLE;
                    end else begin
                        baudCnt_q <= baudCnt_q + BAUD_ONE;
                    end
                end
                default: begin
                    rxState_q <= IDLE;
                    baudCnt_q <= '0;
                end
            endcase
        end
    end

    console_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .reset_i    (RESET),
        .push_i     (rxPush),
        .pushData_i (shift_q),
        .pop_i      (fifoPop),
        .headData_o (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // The head entry stays in the FIFO for the whole handshake and is only
    // removed once the consumer releases ack.
    assign fifoPop = (outState_q == O_ACKED) && !CONSOLE_IN_ack;

    // Output FSM: 4-phase handshake. Returning through O_IDLE guarantees at
    // least one low cycle of valid between consecutive bytes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            outState_q     <= O_IDLE;
            consoleData_q  <= '0;
            consoleValid_q <= 1'b0;
        end else begin
            case (outState_q)
                O_IDLE: begin
                    if (!fifoEmpty) begin
                        consoleData_q  <= fifoHead;
                        consoleValid_q <= 1'b1;
                        outState_q     <= O_VALID;
                    end
                end
                O_VALID: begin
                    if (CONSOLE_IN_ack) begin
                        outState_q <= O_ACKED;
                    end
                end
                O_ACKED: begin
                    if (!CONSOLE_IN_ack) begin
                        consoleValid_q <= 1'b0;
                        outState_q     <= O_IDLE;
                    end
                end
                default: begin
                    consoleValid_q <= 1'b0;
                    outState_q     <= O_IDLE;
                end
            endcase
        end
    end

    assign CONSOLE_IN       = consoleData_q;
    assign CONSOLE_IN_valid = consoleValid_q;
    assign FRAMING_ERR      = framingErr_q;
    assign OVERRUN          = overrun_q;

endmodule

// File: tb/tb_uart_console_in.sv
// ---------------------------------------------------------------------------
// tb_uart_console_in
// Scoreboard bench for uart_console_in with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The stimulus process serialises frames onto RX and pushes the bytes it
// expects to see into expQ; the monitor pops expQ whenever CONSOLE_IN_valid
// rises and checks CONSOLE_IN for as long as valid stays high. A separate
// process plays Wrapper's ack (3 cycles after valid, held 2 cycles).
// Build with UART_PARITY_EN to add the 8E1 parity cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_console_in;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       CLK;
    logic       RESET;
    logic       RX;
    logic [7:0] CONSOLE_IN;
    logic       CONSOLE_IN_valid;
    logic       CONSOLE_IN_ack;
    logic       FRAMING_ERR;
    logic       OVERRUN;

    logic       autoAckEn;
    logic       autoAckLvl;
    logic       manualAck;
`ifdef UART_PARITY_EN
    logic       parityFlip;
`endif

    int         vectors;
    int         miscompares;
    int         feCount;
    int         ovCount;
    logic [7:0] expQ[$];

    assign CONSOLE_IN_ack = autoAckEn ? autoAckLvl : manualAck;

    uart_console_in #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .RX               (RX),
        .CONSOLE_IN       (CONSOLE_IN),
        .CONSOLE_IN_valid (CONSOLE_IN_valid),
        .CONSOLE_IN_ack   (CONSOLE_IN_ack),
        .FRAMING_ERR      (FRAMING_ERR),
        .OVERRUN          (OVERRUN)
    );

    // 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bit on the line for exactly CPB clocks; callers sit #1 after an edge.
    task automatic driveBit(input logic b);
        RX = b;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    // Serialise one frame, LSB first, with an explicit stop-bit level.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(value[i]);
        end
`ifdef UART_PARITY_EN
        driveBit((^value) ^ parityFlip);
`endif
        driveBit(stopBit);
        RX = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Bounded wait for every expected byte to be delivered and released.
    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || CONSOLE_IN_valid) && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput({name, "_pending"}, expQ.size(), 0);
        checkOutput({name, "_idle"}, int'(CONSOLE_IN_valid), 0);
    endtask

    task automatic waitValid(input string name, input int budget);
        int n;
        n = 0;
        while (!CONSOLE_IN_valid && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput(name, int'(CONSOLE_IN_valid), 1);
    endtask

    // Wrapper model: ack 3 cycles after seeing valid, release 2 cycles later.
    initial begin
        autoAckLvl = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (autoAckEn && CONSOLE_IN_valid) begin
                repeat (3) @(posedge CLK);
                #1 autoAckLvl = 1'b1;
                repeat (2) @(posedge CLK);
                #1 autoAckLvl = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on every valid rise, stability while high,
    // and pulse counting for the error outputs.
    initial begin
        logic       prevValid;
        logic       curActive;
        logic [7:0] curExp;
        prevValid = 1'b0;
        curActive = 1'b0;
        curExp    = '0;
        feCount   = 0;
        ovCount   = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (CONSOLE_IN_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    curActive = 1'b0;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", CONSOLE_IN);
                end else begin
                    curExp    = expQ.pop_front();
                    curActive = 1'b1;
                    checkOutput("byte", int'(CONSOLE_IN), int'(curExp));
                end
            end else if (CONSOLE_IN_valid && curActive) begin
                checkOutput("stable", int'(CONSOLE_IN), int'(curExp));
            end
            if (FRAMING_ERR) feCount++;
            if (OVERRUN) ovCount++;
            prevValid = CONSOLE_IN_valid;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int feBase;
        int ovBase;
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b1;
        RX          = 1'b1;
        autoAckEn   = 1'b0;
        manualAck   = 1'b0;
`ifdef UART_PARITY_EN
        parityFlip  = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_valid", int'(CONSOLE_IN_valid), 0);
        checkOutput("reset_data", int'(CONSOLE_IN), 0);
        checkOutput("reset_ferr", int'(FRAMING_ERR), 0);
        checkOutput("reset_ovr", int'(OVERRUN), 0);
        RESET = 1'b0;
        idleCycles(5);

        // Back-to-back bytes with the Wrapper model acking
        $display("[TB] back-to-back bytes");
        autoAckEn = 1'b1;
        expQ.push_back(8'h50);
        expQ.push_back(8'h41);
        expQ.push_back(8'h0D);
        applyStimulus(8'h50, 1'b1);
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h0D, 1'b1);
        waitDrain("b2b", 400);
        idleCycles(5);
        checkOutput("b2b_ferr_count", feCount, 0);
        checkOutput("b2b_ovr_count", ovCount, 0);

        // Long hold without ack, then a manual 4-phase handshake
        $display("[TB] hold without ack");
        autoAckEn = 1'b0;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        waitValid("hold_rise", 50);
        idleCycles(100);
        checkOutput("hold_valid", int'(CONSOLE_IN_valid), 1);
        checkOutput("hold_data", int'(CONSOLE_IN), 8'hA5);
        manualAck = 1'b1;
        idleCycles(3);
        checkOutput("acked_valid", int'(CONSOLE_IN_valid), 1);
        manualAck = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("release_valid", int'(CONSOLE_IN_valid), 0);
        idleCycles(20);
        checkOutput("hold_single_pop", int'(CONSOLE_IN_valid), 0);

        // Overrun: six bytes into a four-entry FIFO with no ack
        $display("[TB] overrun");
        ovBase = ovCount;
        for (int b = 1; b <= 4; b++) expQ.push_back(8'(b));
        for (int b = 1; b <= 6; b++) applyStimulus(8'(b), 1'b1);
        idleCycles(10);
        checkOutput("ovr_count", ovCount - ovBase, 2);
        checkOutput("ovr_valid_held", int'(CONSOLE_IN_valid), 1);
        autoAckEn = 1'b1;
        waitDrain("ovr", 400);
        idleCycles(5);
        checkOutput("ovr_count_final", ovCount - ovBase, 2);

        // Framing error then a good frame
        $display("[TB] framing error");
        feBase = feCount;
        applyStimulus(8'h3C, 1'b0);
        idleCycles(12);
        checkOutput("ferr_pulse", feCount - feBase, 1);
        expQ.push_back(8'h7E);
        applyStimulus(8'h7E, 1'b1);
        waitDrain("ferr_next", 200);
        idleCycles(5);
        checkOutput("ferr_pulse_final", feCount - feBase, 1);

        // One-cycle glitch on an idle line
        $display("[TB] glitch");
        feBase = feCount;
        RX = 1'b0;
        @(posedge CLK);
        #1;
        RX = 1'b1;
        idleCycles(30);
        checkOutput("glitch_ferr", feCount - feBase, 0);
        checkOutput("glitch_valid", int'(CONSOLE_IN_valid), 0);

        // Reset in the middle of a frame with a byte pending
        $display("[TB] reset mid-frame");
        autoAckEn = 1'b0;
        expQ.push_back(8'h55);
        applyStimulus(8'h55, 1'b1);
        waitValid("pending_rise", 50);
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                repeat (12) @(posedge CLK);
                #1 RESET = 1'b1;
                @(posedge CLK);
                #1;
                checkOutput("midreset_valid", int'(CONSOLE_IN_valid), 0);
                checkOutput("midreset_data", int'(CONSOLE_IN), 0);
                RESET = 1'b0;
            end
        join
        idleCycles(40);
        checkOutput("flushed_valid", int'(CONSOLE_IN_valid), 0);
        autoAckEn = 1'b1;
        expQ.push_back(8'h12);
        applyStimulus(8'h12, 1'b1);
        waitDrain("post_reset", 200);

`ifdef UART_PARITY_EN
        // Even parity: correct bit delivers, flipped bit is a framing error
        $display("[TB] parity");
        feBase = feCount;
        parityFlip = 1'b0;
        expQ.push_back(8'h03);
        applyStimulus(8'h03, 1'b1);
        waitDrain("parity_good", 200);
        parityFlip = 1'b1;
        applyStimulus(8'h03, 1'b1);
        idleCycles(20);
        parityFlip = 1'b0;
        checkOutput("parity_bad_ferr", feCount - feBase, 1);
        checkOutput("parity_bad_valid", int'(CONSOLE_IN_valid), 0);
`endif

        idleCycles(10);
        checkOutput("final_queue", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
